reorder_buf: RTL and testbench
==============================

REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 Parameter DEPTH, default 16, entry count; power of two, 4..64.
REQ-002 Parameter XLEN, default 32, data/PC width.
REQ-003 Parameter N_CDB, default 2, number of result-broadcast channels.
REQ-004 Parameter TAG_W, default $clog2(DEPTH), entry tag width.
REQ-005 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 rdy  in  1  global enable; low freezes all state and holds all outputs.
REQ-007 full_o  out  1  no free entry; dispatch must stall.
REQ-008 alloc_valid_i  in  1; alloc_pc_i  in  XLEN; alloc_rd_i  in  5; alloc_is_br_i  in  1; alloc_pred_taken_i  in  1; alloc_is_store_i  in  1  dispatch write.
REQ-009 alloc_tag_o  out  TAG_W  tag assigned to the current alloc (tail index).
REQ-010 qa_tag_i, qb_tag_i  in  TAG_W  operand lookups; qa_ready_o, qb_ready_o  out  1; qa_val_o, qb_val_o  out  XLEN.
REQ-011 cdb_valid_i  in  N_CDB; cdb_tag_i  in  N_CDB*TAG_W; cdb_val_i  in  N_CDB*XLEN; cdb_taken_i  in  N_CDB; cdb_target_i  in  N_CDB*XLEN.
REQ-012 store_go_o  out  1  head is an unfinished store; store_done_i  in  1  LSB finished that store.
REQ-013 commit_valid_o  out  1; commit_rd_o  out  5; commit_val_o  out  XLEN; commit_tag_o  out  TAG_W  register-file write.
REQ-014 bp_upd_o  out  1; bp_pc_o  out  XLEN; bp_taken_o  out  1; bp_hit_o  out  1  predictor training.
REQ-015 flush_o  out  1; flush_pc_o  out  XLEN  mispredict redirect.

Function
REQ-016 Circular buffer with head, tail (TAG_W bits, natural wrap DEPTH-1 -> 0) and count (TAG_W+1 bits); all DEPTH entries usable.
REQ-017 full_o = (count == DEPTH); empty = (count == 0); both combinational from registers.
REQ-018 Alloc accepted iff alloc_valid_i && !full_o && !flush_o; it writes the tail entry, clears ready, and advances tail; alloc while full is ignored.
REQ-019 Each CDB channel k with cdb_valid_i[k] sets ready, val, taken and target of entry cdb_tag_i[k]; if channels collide on one tag, the higher index wins.
REQ-020 Lookup returns entry ready/val, with same-cycle CDB bypass: a matching valid CDB tag forces ready=1 and the CDB value.
REQ-021 store_go_o = !empty && head is store && !head ready; store_done_i marks head ready; store CDB writes are also accepted.
REQ-022 Commit at most one entry per cycle when !empty && head ready; all commit, bp and flush outputs are registered, 1-cycle latency.
REQ-023 commit_valid_o pulses for one cycle only when rd != 0; otherwise it stays 0 and commit_rd_o, commit_val_o and commit_tag_o hold their previous values.
REQ-024 A committing branch pulses bp_upd_o, with bp_taken_o = actual taken and bp_hit_o = (pred == actual).
REQ-025 On mispredict, flush_o pulses with flush_pc_o = taken ? target : pc+4; an rd write for the branch (JALR link) still commits.
REQ-026 While flush_o=1 the next rdy cycle clears head, tail, count, all ready bits, flush_o, commit_valid_o and bp_upd_o; alloc, CDB and commit are ignored that cycle.
REQ-027 Simultaneous alloc and commit leaves count unchanged; when full, a same-cycle commit does not enable alloc.
REQ-028 A CDB write to a non-allocated tag is ignored.

Reset
REQ-029 rst clears head, tail, count, ready, flush_o, commit_valid_o and bp_upd_o, and zeroes all other outputs; rst has priority over rdy; a mid-commit reset discards the pending commit.

Structure
REQ-030 XLEN, the default DEPTH and N_CDB, and the opcode-class constants belong in the shared const include.
REQ-031 One sub-module: rob_cdb_merge, which performs the N_CDB priority merge and lookup bypass.

Verification
REQ-032 Reset, then 16 allocs with no CDB -> full_o=1 after the 16th; the 17th alloc is ignored and tail is unchanged.
REQ-033 Alloc tag 3 with rd=5, CDB0 tag3 val=0xABCD -> next cycle commit_valid_o=1, rd=5, val=0xABCD, tag=3.
REQ-034 Branch pc=0x100 pred=0, CDB taken=1 target=0x200 -> bp_upd_o=1, bp_hit_o=0, flush_o=1, flush_pc_o=0x200; next cycle count=0.
REQ-035 CDB0 and CDB1 on tag 2 with vals 1 and 2, and qa_tag_i=2 the same cycle -> qa_val_o=2 bypassed; entry 2 holds 2.
REQ-036 Store at head -> store_go_o=1; store_done_i -> commit with no commit_valid_o; wrap test DEPTH+5 alloc/commit pairs -> tags wrap 15 -> 0 correctly.

Source files
------------

// File: rtl/reorder_buf_pkg.sv
// rtl/reorder_buf_pkg.sv - shared constants and entry classes for the reorder buffer
package reorder_buf_pkg;

   localparam int ROB_XLEN  = 32;
   localparam int ROB_DEPTH = 16;
   localparam int ROB_N_CDB = 2;

   typedef enum logic [1:0] {
      CLS_ALU = 2'd0,
      CLS_BR  = 2'd1,
      CLS_ST  = 2'd2
   } rob_cls_e;

   function automatic rob_cls_e rob_classify(input logic is_br, input logic is_store);
      if (is_br)
         return CLS_BR;
      else if (is_store)
         return CLS_ST;
      else
         return CLS_ALU;
   endfunction

endpackage

// File: rtl/rob_cdb_merge.sv
// rtl/rob_cdb_merge.sv - per-entry merge of CDB channels and operand lookup with CDB bypass
module rob_cdb_merge
   import reorder_buf_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int XLEN  = ROB_XLEN,
   parameter int N_CDB = ROB_N_CDB,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic [N_CDB-1:0]            cdb_valid_i,
   input  logic [N_CDB*TAG_W-1:0]      cdb_tag_i,
   input  logic [N_CDB*XLEN-1:0]       cdb_val_i,
   input  logic [N_CDB-1:0]            cdb_taken_i,
   input  logic [N_CDB*XLEN-1:0]       cdb_target_i,
   input  logic [DEPTH-1:0]            busy_i,
   input  logic [DEPTH-1:0]            ent_ready_i,
   input  logic [DEPTH-1:0][XLEN-1:0]  ent_val_i,
   input  logic [TAG_W-1:0]            qa_tag_i,
   input  logic [TAG_W-1:0]            qb_tag_i,
   output logic [DEPTH-1:0]            wr_en_o,
   output logic [DEPTH-1:0][XLEN-1:0]  wr_val_o,
   output logic [DEPTH-1:0]            wr_taken_o,
   output logic [DEPTH-1:0][XLEN-1:0]  wr_target_o,
   output logic                        qa_ready_o,
   output logic [XLEN-1:0]             qa_val_o,
   output logic                        qb_ready_o,
   output logic [XLEN-1:0]             qb_val_o
);

   logic [TAG_W-1:0] wr_tag;

   // Ascending scan: a later (higher-index) channel overwrites an earlier one on the same tag.
   always_comb begin
      wr_en_o     = '0;
      wr_val_o    = '0;
      wr_taken_o  = '0;
      wr_target_o = '0;
      wr_tag      = '0;
      for (int k = 0; k < N_CDB; k++) begin
         wr_tag = cdb_tag_i[k*TAG_W +: TAG_W];
         if (cdb_valid_i[k] && busy_i[wr_tag]) begin
            wr_en_o[wr_tag]     = 1'b1;
            wr_val_o[wr_tag]    = cdb_val_i[k*XLEN +: XLEN];
            wr_taken_o[wr_tag]  = cdb_taken_i[k];
            wr_target_o[wr_tag] = cdb_target_i[k*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      qa_ready_o = ent_ready_i[qa_tag_i];
      qa_val_o   = ent_val_i[qa_tag_i];
      qb_ready_o = ent_ready_i[qb_tag_i];
      qb_val_o   = ent_val_i[qb_tag_i];
      for (int k = 0; k < N_CDB; k++) begin
         if (cdb_valid_i[k] && (cdb_tag_i[k*TAG_W +: TAG_W] == qa_tag_i)) begin
            qa_ready_o = 1'b1;
            qa_val_o   = cdb_val_i[k*XLEN +: XLEN];
         end
         if (cdb_valid_i[k] && (cdb_tag_i[k*TAG_W +: TAG_W] == qb_tag_i)) begin
            qb_ready_o = 1'b1;
            qb_val_o   = cdb_val_i[k*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/reorder_buf.sv
// rtl/reorder_buf.sv - circular reorder buffer with in-order commit, branch training and flush
module reorder_buf
   import reorder_buf_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int XLEN  = ROB_XLEN,
   parameter int N_CDB = ROB_N_CDB,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   output logic                   full_o,
   input  logic                   alloc_valid_i,
   input  logic [XLEN-1:0]        alloc_pc_i,
   input  logic [4:0]             alloc_rd_i,
   input  logic                   alloc_is_br_i,
   input  logic                   alloc_pred_taken_i,
   input  logic                   alloc_is_store_i,
   output logic [TAG_W-1:0]       alloc_tag_o,
   input  logic [TAG_W-1:0]       qa_tag_i,
   input  logic [TAG_W-1:0]       qb_tag_i,
   output logic                   qa_ready_o,
   output logic                   qb_ready_o,
   output logic [XLEN-1:0]        qa_val_o,
   output logic [XLEN-1:0]        qb_val_o,
   input  logic [N_CDB-1:0]       cdb_valid_i,
   input  logic [N_CDB*TAG_W-1:0] cdb_tag_i,
   input  logic [N_CDB*XLEN-1:0]  cdb_val_i,
   input  logic [N_CDB-1:0]       cdb_taken_i,
   input  logic [N_CDB*XLEN-1:0]  cdb_target_i,
   output logic                   store_go_o,
   input  logic                   store_done_i,
   output logic                   commit_valid_o,
   output logic [4:0]             commit_rd_o,
   output logic [XLEN-1:0]        commit_val_o,
   output logic [TAG_W-1:0]       commit_tag_o,
   output logic                   bp_upd_o,
   output logic [XLEN-1:0]        bp_pc_o,
   output logic                   bp_taken_o,
   output logic                   bp_hit_o,
   output logic                   flush_o,
   output logic [XLEN-1:0]        flush_pc_o
);

   logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [TAG_W:0]   count_q, count_d;
   logic [DEPTH-1:0] ready_q, ready_d;

   logic [XLEN-1:0]            ent_pc_q     [DEPTH];
   logic [4:0]                 ent_rd_q     [DEPTH];
   rob_cls_e                   ent_cls_q    [DEPTH];
   logic [XLEN-1:0]            ent_target_q [DEPTH];
   logic [DEPTH-1:0]           ent_pred_q, ent_taken_q;
   logic [DEPTH-1:0][XLEN-1:0] ent_val_q;

   logic            commit_valid_q, commit_valid_d;
   logic [4:0]      commit_rd_q, commit_rd_d;
   logic [XLEN-1:0] commit_val_q, commit_val_d;
   logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
   logic            bp_upd_q, bp_upd_d, bp_taken_q, bp_taken_d, bp_hit_q, bp_hit_d;
   logic [XLEN-1:0] bp_pc_q, bp_pc_d;
   logic            flush_q, flush_d;
   logic [XLEN-1:0] flush_pc_q, flush_pc_d;

   logic                       empty, full, alloc_fire, commit_fire, store_go;
   logic                       head_br, head_taken, head_mispred;
   logic [N_CDB-1:0]           cdb_valid_eff;
   logic [DEPTH-1:0]           busy, cdb_wr_en, cdb_wr_taken;
   logic [DEPTH-1:0][XLEN-1:0] cdb_wr_val, cdb_wr_target;

   // An entry is live when its distance from head is below the occupancy count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_busy
      logic [TAG_W-1:0] off;
      assign off     = TAG_W'(i) - head_q;
      assign busy[i] = {1'b0, off} < count_q;
   end

   assign full          = (count_q == (TAG_W+1)'(DEPTH));
   assign empty         = (count_q == '0);
   assign cdb_valid_eff = (rdy && !flush_q) ? cdb_valid_i : '0;
   assign alloc_fire    = rdy && alloc_valid_i && !full && !flush_q;
   assign commit_fire   = rdy && !empty && ready_q[head_q] && !flush_q;
   assign store_go      = !empty && (ent_cls_q[head_q] == CLS_ST) && !ready_q[head_q];
   assign head_br       = (ent_cls_q[head_q] == CLS_BR);
   assign head_taken    = ent_taken_q[head_q];
   assign head_mispred  = head_br && (ent_pred_q[head_q] != head_taken);

   rob_cdb_merge #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN),
      .N_CDB (N_CDB),
      .TAG_W (TAG_W)
   ) u_merge (
      .cdb_valid_i  (cdb_valid_eff),
      .cdb_tag_i    (cdb_tag_i),
      .cdb_val_i    (cdb_val_i),
      .cdb_taken_i  (cdb_taken_i),
      .cdb_target_i (cdb_target_i),
      .busy_i       (busy),
      .ent_ready_i  (ready_q),
      .ent_val_i    (ent_val_q),
      .qa_tag_i     (qa_tag_i),
      .qb_tag_i     (qb_tag_i),
      .wr_en_o      (cdb_wr_en),
      .wr_val_o     (cdb_wr_val),
      .wr_taken_o   (cdb_wr_taken),
      .wr_target_o  (cdb_wr_target),
      .qa_ready_o   (qa_ready_o),
      .qa_val_o     (qa_val_o),
      .qb_ready_o   (qb_ready_o),
      .qb_val_o     (qb_val_o)
   );

   always_comb begin
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      ready_d        = ready_q;
      commit_valid_d = 1'b0;
      commit_rd_d    = commit_rd_q;
      commit_val_d   = commit_val_q;
      commit_tag_d   = commit_tag_q;
      bp_upd_d       = 1'b0;
      bp_pc_d        = bp_pc_q;
      bp_taken_d     = bp_taken_q;
      bp_hit_d       = bp_hit_q;
      flush_d        = 1'b0;
      flush_pc_d     = flush_pc_q;
      if (flush_q) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         ready_d = '0;
      end else begin
         ready_d = ready_q | cdb_wr_en;
         if (store_go && store_done_i)
            ready_d[head_q] = 1'b1;
         if (alloc_fire) begin
            ready_d[tail_q] = 1'b0;
            tail_d          = tail_q + TAG_W'(1);
         end
         if (commit_fire) begin
            head_d = head_q + TAG_W'(1);
            if (ent_rd_q[head_q] != 5'd0) begin
               commit_valid_d = 1'b1;
               commit_rd_d    = ent_rd_q[head_q];
               commit_val_d   = ent_val_q[head_q];
               commit_tag_d   = head_q;
            end
            if (head_br) begin
               bp_upd_d   = 1'b1;
               bp_pc_d    = ent_pc_q[head_q];
               bp_taken_d = head_taken;
               bp_hit_d   = !head_mispred;
            end
            if (head_mispred) begin
               flush_d    = 1'b1;
               flush_pc_d = head_taken ? ent_target_q[head_q] : ent_pc_q[head_q] + XLEN'(4);
            end
         end
         case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + (TAG_W+1)'(1);
            2'b01:   count_d = count_q - (TAG_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         ready_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_rd_q    <= '0;
         commit_val_q   <= '0;
         commit_tag_q   <= '0;
         bp_upd_q       <= 1'b0;
         bp_pc_q        <= '0;
         bp_taken_q     <= 1'b0;
         bp_hit_q       <= 1'b0;
         flush_q        <= 1'b0;
         flush_pc_q     <= '0;
      end else if (rdy) begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         ready_q        <= ready_d;
         commit_valid_q <= commit_valid_d;
         commit_rd_q    <= commit_rd_d;
         commit_val_q   <= commit_val_d;
         commit_tag_q   <= commit_tag_d;
         bp_upd_q       <= bp_upd_d;
         bp_pc_q        <= bp_pc_d;
         bp_taken_q     <= bp_taken_d;
         bp_hit_q       <= bp_hit_d;
         flush_q        <= flush_d;
         flush_pc_q     <= flush_pc_d;
      end
   end

   // Payload storage needs no reset: an entry's ready bit gates every use of it.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         ent_pc_q[tail_q]   <= alloc_pc_i;
         ent_rd_q[tail_q]   <= alloc_rd_i;
         ent_cls_q[tail_q]  <= rob_classify(alloc_is_br_i, alloc_is_store_i);
         ent_pred_q[tail_q] <= alloc_pred_taken_i;
      end
      for (int e = 0; e < DEPTH; e++) begin
         if (cdb_wr_en[e]) begin
            ent_val_q[e]    <= cdb_wr_val[e];
            ent_taken_q[e]  <= cdb_wr_taken[e];
            ent_target_q[e] <= cdb_wr_target[e];
         end
      end
   end

   assign full_o         = full;
   assign alloc_tag_o    = tail_q;
   assign store_go_o     = store_go;
   assign commit_valid_o = commit_valid_q;
   assign commit_rd_o    = commit_rd_q;
   assign commit_val_o   = commit_val_q;
   assign commit_tag_o   = commit_tag_q;
   assign bp_upd_o       = bp_upd_q;
   assign bp_pc_o        = bp_pc_q;
   assign bp_taken_o     = bp_taken_q;
   assign bp_hit_o       = bp_hit_q;
   assign flush_o        = flush_q;
   assign flush_pc_o     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buf.sv
// tb/tb_reorder_buf.sv - scoreboard bench for reorder_buf: directed stimulus, monitor-side commit/bp/flush checks
module tb_reorder_buf;

   localparam int DEPTH = 16;
   localparam int XLEN  = 32;
   localparam int N_CDB = 2;
   localparam int TAG_W = 4;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   rdy = 1'b1;
   logic                   full_o;
   logic                   alloc_valid_i = 1'b0;
   logic [XLEN-1:0]        alloc_pc_i = '0;
   logic [4:0]             alloc_rd_i = '0;
   logic                   alloc_is_br_i = 1'b0;
   logic                   alloc_pred_taken_i = 1'b0;
   logic                   alloc_is_store_i = 1'b0;
   logic [TAG_W-1:0]       alloc_tag_o;
   logic [TAG_W-1:0]       qa_tag_i = '0;
   logic [TAG_W-1:0]       qb_tag_i = '0;
   logic                   qa_ready_o, qb_ready_o;
   logic [XLEN-1:0]        qa_val_o, qb_val_o;
   logic [N_CDB-1:0]       cdb_valid_i = '0;
   logic [N_CDB*TAG_W-1:0] cdb_tag_i = '0;
   logic [N_CDB*XLEN-1:0]  cdb_val_i = '0;
   logic [N_CDB-1:0]       cdb_taken_i = '0;
   logic [N_CDB*XLEN-1:0]  cdb_target_i = '0;
   logic                   store_go_o;
   logic                   store_done_i = 1'b0;
   logic                   commit_valid_o;
   logic [4:0]             commit_rd_o;
   logic [XLEN-1:0]        commit_val_o;
   logic [TAG_W-1:0]       commit_tag_o;
   logic                   bp_upd_o, bp_taken_o, bp_hit_o;
   logic [XLEN-1:0]        bp_pc_o;
   logic                   flush_o;
   logic [XLEN-1:0]        flush_pc_o;

   reorder_buf #(.DEPTH(DEPTH), .XLEN(XLEN), .N_CDB(N_CDB), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .full_o(full_o),
      .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i), .alloc_rd_i(alloc_rd_i),
      .alloc_is_br_i(alloc_is_br_i), .alloc_pred_taken_i(alloc_pred_taken_i),
      .alloc_is_store_i(alloc_is_store_i), .alloc_tag_o(alloc_tag_o),
      .qa_tag_i(qa_tag_i), .qb_tag_i(qb_tag_i), .qa_ready_o(qa_ready_o), .qb_ready_o(qb_ready_o),
      .qa_val_o(qa_val_o), .qb_val_o(qb_val_o),
      .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_val_i(cdb_val_i),
      .cdb_taken_i(cdb_taken_i), .cdb_target_i(cdb_target_i),
      .store_go_o(store_go_o), .store_done_i(store_done_i),
      .commit_valid_o(commit_valid_o), .commit_rd_o(commit_rd_o), .commit_val_o(commit_val_o),
      .commit_tag_o(commit_tag_o), .bp_upd_o(bp_upd_o), .bp_pc_o(bp_pc_o),
      .bp_taken_o(bp_taken_o), .bp_hit_o(bp_hit_o), .flush_o(flush_o), .flush_pc_o(flush_pc_o)
   );

   always #5 clk = ~clk;

   typedef struct { logic [4:0] rd; logic [31:0] val; logic [3:0] tag; } cexp_t;
   typedef struct { logic [31:0] pc; logic taken; logic hit; } bexp_t;

   cexp_t       cq[$];
   bexp_t       bq[$];
   logic [31:0] fq[$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      alloc_valid_i = 1'b0;
      cdb_valid_i   = '0;
      store_done_i  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic do_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic br,
                           input logic pred, input logic st);
      alloc_valid_i      = 1'b1;
      alloc_pc_i         = pc;
      alloc_rd_i         = rd;
      alloc_is_br_i      = br;
      alloc_pred_taken_i = pred;
      alloc_is_store_i   = st;
   endtask

   task automatic set_cdb(input int ch, input logic [3:0] tag, input logic [31:0] val,
                          input logic tk, input logic [31:0] tgt);
      cdb_valid_i[ch]            = 1'b1;
      cdb_tag_i[ch*TAG_W +: TAG_W] = tag;
      cdb_val_i[ch*XLEN +: XLEN]   = val;
      cdb_taken_i[ch]            = tk;
      cdb_target_i[ch*XLEN +: XLEN] = tgt;
   endtask

   // Monitor: every output pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (commit_valid_o) begin
         if (cq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL commit_unexpected tag=%0d rd=%0d val=0x%0h required=none", commit_tag_o, commit_rd_o, commit_val_o);
         end else begin
            cexp_t ce;
            ce = cq.pop_front();
            chk("commit_rd", 32'(commit_rd_o), 32'(ce.rd));
            chk("commit_val", commit_val_o, ce.val);
            chk("commit_tag", 32'(commit_tag_o), 32'(ce.tag));
         end
      end
      if (bp_upd_o) begin
         if (bq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bp_unexpected pc=0x%0h required=none", bp_pc_o);
         end else begin
            bexp_t be;
            be = bq.pop_front();
            chk("bp_pc", bp_pc_o, be.pc);
            chk("bp_taken", 32'(bp_taken_o), 32'(be.taken));
            chk("bp_hit", 32'(bp_hit_o), 32'(be.hit));
         end
      end
      if (flush_o) begin
         if (fq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL flush_unexpected pc=0x%0h required=none", flush_pc_o);
         end else begin
            logic [31:0] fe;
            fe = fq.pop_front();
            chk("flush_pc", flush_pc_o, fe);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, fill to full, overflow alloc ignored
      do_reset();
      chk("rst_full", 32'(full_o), 32'd0);
      chk("rst_tag", 32'(alloc_tag_o), 32'd0);
      chk("rst_commit_valid", 32'(commit_valid_o), 32'd0);
      chk("rst_bp_upd", 32'(bp_upd_o), 32'd0);
      chk("rst_flush", 32'(flush_o), 32'd0);
      chk("rst_flush_pc", flush_pc_o, 32'd0);
      chk("rst_store_go", 32'(store_go_o), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("fill_full_before", 32'(full_o), 32'd0);
         do_alloc(32'h40 + 32'(i * 4), 5'd0, 1'b0, 1'b0, 1'b0);
         cyc();
      end
      chk("fill_full", 32'(full_o), 32'd1);
      chk("fill_tag_wrap", 32'(alloc_tag_o), 32'd0);
      do_alloc(32'h80, 5'd9, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("overflow_tag", 32'(alloc_tag_o), 32'd0);
      chk("overflow_full", 32'(full_o), 32'd1);

      // Reset landing on the commit cycle discards the commit
      do_reset();
      do_alloc(32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
      cyc();
      set_cdb(0, 4'd0, 32'h44, 1'b0, 32'h0);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_commit_valid", 32'(commit_valid_o), 32'd0);
      chk("midrst_tag", 32'(alloc_tag_o), 32'd0);
      cyc();

      // Commit with rd write, one-cycle latency after CDB
      do_reset();
      do_alloc(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc();
      do_alloc(32'h4, 5'd7, 1'b0, 1'b0, 1'b0);
      set_cdb(0, 4'd0, 32'h0, 1'b0, 32'h0);
      cyc();
      do_alloc(32'h8, 5'd0, 1'b0, 1'b0, 1'b0);
      set_cdb(0, 4'd1, 32'h11, 1'b0, 32'h0);
      cq.push_back('{5'd7, 32'h11, 4'd1});
      cyc();
      chk("alloc_tag3", 32'(alloc_tag_o), 32'd3);
      do_alloc(32'hC, 5'd5, 1'b0, 1'b0, 1'b0);
      set_cdb(0, 4'd2, 32'h0, 1'b0, 32'h0);
      cyc();
      cyc();
      cyc();
      set_cdb(0, 4'd3, 32'hABCD, 1'b0, 32'h0);
      cq.push_back('{5'd5, 32'hABCD, 4'd3});
      cyc();
      chk("commit_latency_0", 32'(commit_valid_o), 32'd0);
      cyc();
      chk("commit_latency_1", 32'(commit_valid_o), 32'd1);
      repeat (3) cyc();

      // Mispredicted branch: flush, younger entry discarded, alloc in flush cycle ignored
      do_reset();
      do_alloc(32'h100, 5'd0, 1'b1, 1'b0, 1'b0);
      cyc();
      do_alloc(32'h104, 5'd3, 1'b0, 1'b0, 1'b0);
      set_cdb(0, 4'd0, 32'h0, 1'b1, 32'h200);
      bq.push_back('{32'h100, 1'b1, 1'b0});
      fq.push_back(32'h200);
      cyc();
      set_cdb(1, 4'd1, 32'h77, 1'b0, 32'h0);
      cyc();
      chk("flush_pulse", 32'(flush_o), 32'd1);
      do_alloc(32'h108, 5'd6, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("flush_clear_tag", 32'(alloc_tag_o), 32'd0);
      chk("flush_clear_full", 32'(full_o), 32'd0);
      chk("flush_done", 32'(flush_o), 32'd0);
      qa_tag_i = 4'd1;
      #1;
      chk("flush_ready_cleared", 32'(qa_ready_o), 32'd0);
      cyc();

      // Link-writing branch, predicted taken but not taken: commits rd and redirects to pc+4
      do_alloc(32'h300, 5'd1, 1'b1, 1'b1, 1'b0);
      cyc();
      set_cdb(0, 4'd0, 32'h304, 1'b0, 32'h999);
      cq.push_back('{5'd1, 32'h304, 4'd0});
      bq.push_back('{32'h300, 1'b0, 1'b0});
      fq.push_back(32'h304);
      cyc();
      repeat (3) cyc();

      // Correctly predicted branch: training pulse, no flush
      do_alloc(32'h500, 5'd0, 1'b1, 1'b1, 1'b0);
      cyc();
      set_cdb(0, 4'd0, 32'h0, 1'b1, 32'h600);
      bq.push_back('{32'h500, 1'b1, 1'b1});
      cyc();
      repeat (3) cyc();
      chk("hit_no_flush", 32'(flush_o), 32'd0);

      // CDB collision on one tag with same-cycle lookup bypass
      do_reset();
      do_alloc(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc();
      do_alloc(32'h4, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc();
      do_alloc(32'h8, 5'd9, 1'b0, 1'b0, 1'b0);
      cyc();
      set_cdb(0, 4'd2, 32'd1, 1'b0, 32'h0);
      set_cdb(1, 4'd2, 32'd2, 1'b0, 32'h0);
      qa_tag_i = 4'd2;
      qb_tag_i = 4'd1;
      #1;
      chk("bypass_qa_ready", 32'(qa_ready_o), 32'd1);
      chk("bypass_qa_val", qa_val_o, 32'd2);
      chk("bypass_qb_ready", 32'(qb_ready_o), 32'd0);
      cyc();
      chk("stored_qa_ready", 32'(qa_ready_o), 32'd1);
      chk("stored_qa_val", qa_val_o, 32'd2);
      set_cdb(0, 4'd5, 32'h55, 1'b0, 32'h0);
      cyc();
      qa_tag_i = 4'd5;
      #1;
      chk("unalloc_ignored", 32'(qa_ready_o), 32'd0);
      set_cdb(0, 4'd0, 32'h0, 1'b0, 32'h0);
      set_cdb(1, 4'd1, 32'h0, 1'b0, 32'h0);
      cq.push_back('{5'd9, 32'd2, 4'd2});
      cyc();
      repeat (4) cyc();

      // Store at head waits for store_done and commits without a register write
      do_reset();
      do_alloc(32'h700, 5'd0, 1'b0, 1'b0, 1'b1);
      cyc();
      chk("store_go", 32'(store_go_o), 32'd1);
      store_done_i = 1'b1;
      cyc();
      chk("store_go_done", 32'(store_go_o), 32'd0);
      cyc();
      chk("store_committed_tag", 32'(alloc_tag_o), 32'd1);

      // Wrap: DEPTH+5 alloc/commit pairs walking tags through 15 -> 0
      for (int i = 0; i < DEPTH + 5; i++) begin
         logic [3:0] wtag;
         wtag = 4'((1 + i) % DEPTH);
         chk("wrap_tag", 32'(alloc_tag_o), 32'(wtag));
         do_alloc(32'h2000 + 32'(i * 4), 5'((i % 31) + 1), 1'b0, 1'b0, 1'b0);
         if (i > 0) begin
            set_cdb(0, wtag - 4'd1, 32'h1000 + 32'(i - 1), 1'b0, 32'h0);
            cq.push_back('{5'(((i - 1) % 31) + 1), 32'h1000 + 32'(i - 1), wtag - 4'd1});
         end
         cyc();
      end
      set_cdb(0, 4'd5, 32'h1000 + 32'd20, 1'b0, 32'h0);
      cq.push_back('{5'd21, 32'h1000 + 32'd20, 4'd5});
      cyc();
      repeat (3) cyc();

      // rdy low freezes allocation
      chk("pre_freeze_tag", 32'(alloc_tag_o), 32'd6);
      rdy = 1'b0;
      do_alloc(32'h3000, 5'd2, 1'b0, 1'b0, 1'b0);
      cyc();
      do_alloc(32'h3004, 5'd2, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("freeze_tag", 32'(alloc_tag_o), 32'd6);
      rdy = 1'b1;
      cyc();
      chk("unfreeze_tag", 32'(alloc_tag_o), 32'd6);

      repeat (3) cyc();
      chk("commit_queue_drained", 32'(cq.size()), 32'd0);
      chk("bp_queue_drained", 32'(bq.size()), 32'd0);
      chk("flush_queue_drained", 32'(fq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
